// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants and capture FSM states
// Purpose: single source of VGA timing shared by the generator and the capture side.
// Ports: none (package).
package vga_timing_pkg;

   localparam int H_TOTAL     = 800;
   localparam int H_SYNC      = 96;
   localparam int H_BP        = 48;
   localparam int H_ACTIVE    = 640;
   localparam int V_TOTAL     = 521;
   localparam int V_SYNC      = 2;
   localparam int V_BP        = 29;
   localparam int V_ACTIVE    = 480;
   localparam int LOCK_FRAMES = 2;

   localparam int CNT_W   = 10;
   localparam int H_FIRST = H_SYNC + H_BP;
   localparam int H_END   = H_FIRST + H_ACTIVE;
   localparam int V_FIRST = V_SYNC + V_BP;
   localparam int V_END   = V_FIRST + V_ACTIVE;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } sync_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - registered sync input with falling-edge strobe
// Purpose: samples one sync pin once and flags a high-to-low transition between samples.
// Ports:
//   clk    in  pixel clock
//   clr_n  in  synchronous reset, active low
//   din    in  raw sync pin
//   level  out registered sample of din
//   fall   out high for one cycle when level goes 1 -> 0
module vga_sync_edge (
   input  logic clk,
   input  logic clr_n,
   input  logic din,
   output logic level,
   output logic fall
);

   logic prev;

   // Both flops clear to 0 so a pin that is low when reset releases never looks like a fall.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         level <= 1'b0;
         prev  <= 1'b0;
      end else begin
         level <= din;
         prev  <= level;
      end
   end

   assign fall = prev & ~level;

endmodule

// File: rtl/vga_sync_capture.sv
// rtl/vga_sync_capture.sv - VGA receive-side sync checker and qualified pixel capture
// Purpose: recovers pixel coordinates from hsync/vsync, verifies line/frame timing, locks
//   after LOCK_FRAMES good frames and then emits a qualified RGB332 pixel stream.
// Ports:
//   clk25      in  pixel clock
//   clr_n      in  synchronous reset, active low
//   hsync      in  horizontal sync, active low
//   vsync      in  vertical sync, active low
//   red/green/blue in  RGB332 pixel
//   pix_valid  out active pixel on pix_rgb/px_x/px_y (locked only)
//   pix_rgb    out captured {red,green,blue}
//   px_x/px_y  out active column / row
//   sof        out first pixel of frame
//   eol        out last pixel of line
//   locked     out timing verified
//   sync_err   out one-cycle pulse per timing violation
module vga_sync_capture
   import vga_timing_pkg::*;
#(
   parameter int P_H_TOTAL     = H_TOTAL,
   parameter int P_H_SYNC      = H_SYNC,
   parameter int P_H_BP        = H_BP,
   parameter int P_H_ACTIVE    = H_ACTIVE,
   parameter int P_V_TOTAL     = V_TOTAL,
   parameter int P_V_SYNC      = V_SYNC,
   parameter int P_V_BP        = V_BP,
   parameter int P_V_ACTIVE    = V_ACTIVE,
   parameter int P_LOCK_FRAMES = LOCK_FRAMES
) (
   input  logic             clk25,
   input  logic             clr_n,
   input  logic             hsync,
   input  logic             vsync,
   input  logic [2:0]       red,
   input  logic [2:0]       green,
   input  logic [1:0]       blue,
   output logic             pix_valid,
   output logic [7:0]       pix_rgb,
   output logic [CNT_W-1:0] px_x,
   output logic [CNT_W-1:0] px_y,
   output logic             sof,
   output logic             eol,
   output logic             locked,
   output logic             sync_err
);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(P_H_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_TMO  = CNT_W'(P_H_TOTAL);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(P_V_TOTAL - 1);
   localparam logic [CNT_W-1:0] HF     = CNT_W'(P_H_SYNC + P_H_BP);
   localparam logic [CNT_W-1:0] HE     = CNT_W'(P_H_SYNC + P_H_BP + P_H_ACTIVE);
   localparam logic [CNT_W-1:0] VF     = CNT_W'(P_V_SYNC + P_V_BP);
   localparam logic [CNT_W-1:0] VE     = CNT_W'(P_V_SYNC + P_V_BP + P_V_ACTIVE);
   localparam logic [CNT_W-1:0] X_LAST = CNT_W'(P_H_ACTIVE - 1);
   localparam logic [3:0]       GOOD_N = 4'(P_LOCK_FRAMES);

   logic             hs_level, hs_fall, vs_level, vs_fall;
   logic             level_unused;
   logic [7:0]       rgb_q;
   logic [CNT_W-1:0] hcnt, vcnt, hpos, vpos;
   logic             tmo;
   logic             line_bad, line_tmo, frame_bad, viol, active;
   logic [3:0]       good;
   sync_state_t      state;

   vga_sync_edge u_hs (.clk(clk25), .clr_n(clr_n), .din(hsync), .level(hs_level), .fall(hs_fall));
   vga_sync_edge u_vs (.clk(clk25), .clr_n(clr_n), .din(vsync), .level(vs_level), .fall(vs_fall));

   assign level_unused = hs_level ^ vs_level;

   // Colour takes the same single register stage as the sync pins so they stay aligned.
   always_ff @(posedge clk25) begin
      if (!clr_n) rgb_q <= '0;
      else        rgb_q <= {red, green, blue};
   end

   // hcnt/vcnt hold the position of the previous sample; hpos/vpos are the position of the
   // sample currently in the input register. Both counters saturate instead of wrapping.
   always_comb begin
      hpos = hs_fall ? '0 : ((hcnt == '1) ? hcnt : hcnt + CNT_W'(1));
      vpos = vcnt;
      if (vs_fall)
         vpos = '0;
      else if (hs_fall && vcnt != '1)
         vpos = vcnt + CNT_W'(1);
      // The fall that ends a timed-out line was already reported by the timeout.
      line_bad  = hs_fall && !tmo && (hcnt != H_LAST);
      line_tmo  = !hs_fall && !tmo && (hpos == H_TMO);
      frame_bad = vs_fall && (vcnt != V_LAST);
      viol      = line_bad || line_tmo || frame_bad;
      active    = (hpos >= HF) && (hpos < HE) && (vpos >= VF) && (vpos < VE);
   end

   always_ff @(posedge clk25) begin
      if (!clr_n) begin
         hcnt      <= '0;
         vcnt      <= '0;
         tmo       <= 1'b0;
         good      <= '0;
         state     <= SEARCH;
         locked    <= 1'b0;
         sync_err  <= 1'b0;
         pix_valid <= 1'b0;
         pix_rgb   <= '0;
         px_x      <= '0;
         px_y      <= '0;
         sof       <= 1'b0;
         eol       <= 1'b0;
      end else begin
         hcnt <= hpos;
         vcnt <= vpos;
         if (hs_fall)       tmo <= 1'b0;
         else if (line_tmo) tmo <= 1'b1;

         sync_err  <= 1'b0;
         pix_valid <= 1'b0;
         pix_rgb   <= '0;
         px_x      <= '0;
         px_y      <= '0;
         sof       <= 1'b0;
         eol       <= 1'b0;

         case (state)
            SEARCH: begin
               if (vs_fall) begin
                  state <= MEASURE;
                  good  <= '0;
               end
            end
            MEASURE: begin
               if (viol) begin
                  good     <= '0;
                  sync_err <= 1'b1;
               end else if (vs_fall) begin
                  good <= good + 4'd1;
                  if (good + 4'd1 == GOOD_N) begin
                     state  <= LOCKED;
                     locked <= 1'b1;
                  end
               end
            end
            LOCKED: begin
               if (viol) begin
                  sync_err <= 1'b1;
                  locked   <= 1'b0;
                  good     <= '0;
                  state    <= MEASURE;
               end else if (active) begin
                  pix_valid <= 1'b1;
                  pix_rgb   <= rgb_q;
                  px_x      <= hpos - HF;
                  px_y      <= vpos - VF;
                  sof       <= (hpos == HF) && (vpos == VF);
                  eol       <= (hpos - HF) == X_LAST;
               end
            end
            default: begin
               state  <= SEARCH;
               good   <= '0;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_sync_capture.sv
// tb/tb_vga_sync_capture.sv - directed bench for vga_sync_capture on scaled-down timing
module tb_vga_sync_capture;

   localparam int HT = 40, HS = 4, HB = 6, HA = 24;
   localparam int VT = 20, VS = 2, VB = 3, VA = 12;
   localparam int HF = HS + HB, HE = HF + HA;
   localparam int VF = VS + VB, VE = VF + VA;
   localparam int SHORT_F = 4,  SHORT_V = 8;
   localparam int MASK_F  = 7,  MASK_V  = 8;
   localparam int SHORTFR = 10;
   localparam int BUDGET  = 5000;

   logic       clk25 = 1'b0;
   logic       clr_n;
   logic       hsync, vsync;
   logic [2:0] red, green;
   logic [1:0] blue;
   logic       pix_valid, sof, eol, locked, sync_err;
   logic [7:0] pix_rgb;
   logic [9:0] px_x, px_y;

   int n_checks = 0, n_fail = 0;
   int hc, vc, fcount;
   int h0 = -1, h1 = -1, h2 = -1, v0 = -1, v1 = -1, v2 = -1, f0 = -1, f1 = -1, f2 = -1;
   int mon_frame = 3;
   int pv_cnt = 0, sof_cnt = 0, eol_cnt = 0, bad_cnt = 0, err_cnt = 0;
   int err_snap;

   vga_sync_capture #(
      .P_H_TOTAL(HT), .P_H_SYNC(HS), .P_H_BP(HB), .P_H_ACTIVE(HA),
      .P_V_TOTAL(VT), .P_V_SYNC(VS), .P_V_BP(VB), .P_V_ACTIVE(VA), .P_LOCK_FRAMES(2)
   ) dut (
      .clk25(clk25), .clr_n(clr_n), .hsync(hsync), .vsync(vsync),
      .red(red), .green(green), .blue(blue),
      .pix_valid(pix_valid), .pix_rgb(pix_rgb), .px_x(px_x), .px_y(px_y),
      .sof(sof), .eol(eol), .locked(locked), .sync_err(sync_err)
   );

   always #5 clk25 = ~clk25;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] colour(input int h, input int v);
      return 8'(h * 3 + v * 7);
   endfunction

   function automatic int line_len();
      return (fcount == SHORT_F && vc == SHORT_V) ? HT - 10 : HT;
   endfunction

   function automatic int frame_len();
      return (fcount == SHORTFR) ? VT - 1 : VT;
   endfunction

   task automatic drive_pins();
      logic [7:0] c;
      hsync = (hc >= HS) || (fcount == MASK_F && vc == MASK_V);
      vsync = (vc >= VS);
      c = (hc >= HF && hc < HE && vc >= VF && vc < VE) ? colour(hc, vc) : 8'd0;
      {red, green, blue} = c;
   endtask

   // Generator: pins for position (hc,vc) are driven 1 ns after each rising edge.
   initial begin
      hc = 0; vc = 0; fcount = 0;
      drive_pins();
      forever begin
         @(posedge clk25);
         #1;
         if (hc == line_len() - 1) begin
            hc = 0;
            if (vc == frame_len() - 1) begin
               vc = 0;
               fcount++;
            end else begin
               vc++;
            end
         end else begin
            hc++;
         end
         drive_pins();
      end
   end

   // Outputs seen at a falling edge belong to the pins driven two cycles earlier.
   initial begin
      logic exp_v;
      forever begin
         @(negedge clk25);
         h2 = h1; v2 = v1; f2 = f1;
         h1 = h0; v1 = v0; f1 = f0;
         h0 = hc; v0 = vc; f0 = fcount;
         if (sync_err) err_cnt++;
         if (f2 == mon_frame) begin
            exp_v = (h2 >= HF && h2 < HE && v2 >= VF && v2 < VE);
            if (pix_valid) pv_cnt++;
            if (sof) sof_cnt++;
            if (eol) eol_cnt++;
            if (pix_valid != exp_v)
               bad_cnt++;
            else if (exp_v && (int'(px_x) != h2 - HF || int'(px_y) != v2 - VF ||
                               pix_rgb != colour(h2, v2) ||
                               sof != (h2 == HF && v2 == VF) || eol != (h2 == HE - 1)))
               bad_cnt++;
         end
      end
   end

   task automatic wait_gen(input int f, input int h, input int v);
      int n;
      n = 0;
      do begin
         @(negedge clk25);
         n++;
      end while (!(fcount == f && hc == h && vc == v) && n < BUDGET);
      if (n >= BUDGET) chk("wait_timeout", n, 0);
   endtask

   initial begin
      clr_n = 1'b0;
      repeat (3) @(negedge clk25);
      chk("rst_locked", locked, 0);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_sync_err", sync_err, 0);
      chk("rst_px_x", px_x, 0);
      chk("rst_pix_rgb", pix_rgb, 0);
      clr_n = 1'b1;

      // Lock on the third vsync fall after reset.
      wait_gen(3, 1, 0);
      chk("lock_not_yet", locked, 0);
      wait_gen(3, 2, 0);
      chk("lock_asserted", locked, 1);

      // Frame 3 is the first qualified frame.
      wait_gen(4, 5, 0);
      chk("frame_pix_count", pv_cnt, HA * VA);
      chk("frame_sof_count", sof_cnt, 1);
      chk("frame_eol_count", eol_cnt, VA);
      chk("frame_pixel_errors", bad_cnt, 0);

      // Short line: hsync falls at hcnt = HT-10.
      err_snap = err_cnt;
      wait_gen(SHORT_F, 1, SHORT_V + 1);
      chk("short_pre_locked", locked, 1);
      chk("short_pre_err", sync_err, 0);
      wait_gen(SHORT_F, 2, SHORT_V + 1);
      chk("short_err", sync_err, 1);
      chk("short_unlocked", locked, 0);
      chk("short_pix_valid", pix_valid, 0);
      wait_gen(SHORT_F, 3, SHORT_V + 1);
      chk("short_err_one_cycle", sync_err, 0);
      wait_gen(6, 1, 0);
      chk("short_err_pulses", err_cnt - err_snap, 1);
      chk("short_relock_pre", locked, 0);
      wait_gen(6, 2, 0);
      chk("short_relock", locked, 1);

      // Missing hsync pulse: timeout at hcnt = HT.
      wait_gen(MASK_F, 1, MASK_V);
      chk("tmo_pre_locked", locked, 1);
      err_snap = err_cnt;
      wait_gen(MASK_F, 2, MASK_V);
      chk("tmo_err", sync_err, 1);
      chk("tmo_unlocked", locked, 0);
      wait_gen(MASK_F, 5, MASK_V + 2);
      chk("tmo_err_pulses", err_cnt - err_snap, 1);
      wait_gen(MASK_F + 1, 2, 0);
      chk("tmo_frame_err", sync_err, 1);
      wait_gen(SHORTFR, 2, 0);
      chk("tmo_relock", locked, 1);

      // Frame one line short.
      wait_gen(SHORTFR + 1, 1, 0);
      chk("vshort_pre_locked", locked, 1);
      wait_gen(SHORTFR + 1, 2, 0);
      chk("vshort_err", sync_err, 1);
      chk("vshort_unlocked", locked, 0);
      wait_gen(SHORTFR + 3, 1, 0);
      chk("vshort_relock_pre", locked, 0);
      wait_gen(SHORTFR + 3, 2, 0);
      chk("vshort_relock", locked, 1);

      // One-cycle reset in the middle of an active line.
      wait_gen(13, 12, 10);
      chk("mid_pix_valid", pix_valid, 1);
      chk("mid_px_x", px_x, 0);
      clr_n = 1'b0;
      @(negedge clk25);
      clr_n = 1'b1;
      chk("clr_pix_valid", pix_valid, 0);
      chk("clr_locked", locked, 0);
      chk("clr_px_y", px_y, 0);
      chk("clr_pix_rgb", pix_rgb, 0);
      wait_gen(14, 15, 10);
      chk("clr_no_pixels", pix_valid, 0);
      wait_gen(16, 1, 0);
      chk("clr_relock_pre", locked, 0);
      wait_gen(16, 2, 0);
      chk("clr_relock", locked, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
